// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out shifter, the transmit-side partner of the SIPO receiver.
//
// A WIDTH-bit word is accepted through a valid/ready handshake. It is then streamed out one bit
// per enabled clock. Back-to-back words are supported: the next word is accepted on the last-bit
// edge, so there is no idle gap between frames.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first (shift left); 0: bit 0 goes out first (shift right)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   load_valid    parallel_in holds a word to send
//   load_ready    a word can be accepted this cycle (combinational, depends on shift_en)
//   parallel_in   word to serialise, sampled only on an accept
//   shift_en      advance enable; 0 holds the current bit
//   serial_out    current serial bit (0 when idle)
//   serial_valid  serial_out carries a frame bit
//   last_bit      serial_out is the final bit of the current word
//   busy          a frame is in progress (same as serial_valid)
module piso_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Move the register one place toward the output end, filling with zero.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {v[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, v[WIDTH-1:1]};
        end
        return r;
    endfunction

    // Next-state logic and handshake ready.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        load_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    sreg_d  = parallel_in;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    if (cnt_q == CNT_LAST) begin
                        // End of frame: a waiting word chains in with no bubble.
                        load_ready = 1'b1;
                        cnt_d      = {CNT_W{1'b0}};
                        if (load_valid) begin
                            sreg_d  = parallel_in;
                            state_d = ST_SHIFT;
                        end else begin
                            // The final shift leaves sreg all-zero while idle.
                            sreg_d  = shift_one(sreg_q);
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sreg_d = shift_one(sreg_q);
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sreg_d  = {WIDTH{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, shift register and bit counter flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Serial outputs decoded purely from registered state.
    always_comb begin
        serial_valid = 1'b0;
        serial_out   = 1'b0;
        last_bit     = 1'b0;
        if (state_q == ST_SHIFT) begin
            serial_valid = 1'b1;
            serial_out   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
            last_bit     = (cnt_q == CNT_LAST);
        end else begin
            serial_valid = 1'b0;
        end
        busy = serial_valid;
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: an MSB-first and an LSB-first instance share the clock and control.
// Each is compared every cycle against a per-word bit-position model. A loopback SIPO on the
// MSB-first instance checks word reassembly.
module tb_piso_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic       shift_en = 1'b1;
    logic [3:0] pin [2];
    logic       lr [2];
    logic       so [2];
    logic       sv [2];
    logic       lb [2];
    logic       bz [2];
    logic [3:0] sipo;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: current word, number of bits already sent, frame active flag.
    logic [3:0] mword [2];
    int         mpos  [2];
    bit         mact  [2];
    bit         msbf  [2];

    bit cap0 [$];
    bit cap1 [$];

    always #5 clk = ~clk;

    piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr[0]),
        .parallel_in(pin[0]), .shift_en(shift_en), .serial_out(so[0]),
        .serial_valid(sv[0]), .last_bit(lb[0]), .busy(bz[0])
    );

    piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr[1]),
        .parallel_in(pin[1]), .shift_en(shift_en), .serial_out(so[1]),
        .serial_valid(sv[1]), .last_bit(lb[1]), .busy(bz[1])
    );

    // Loopback receiver: shift-left fill on every enabled valid bit.
    always @(posedge clk) begin
        if (rst) sipo <= 4'b0000;
        else if (sv[0] && shift_en) sipo <= {sipo[2:0], so[0]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input bit q [$]);
        logic [31:0] v = 32'd0;
        foreach (q[k]) v = {v[30:0], q[k]};
        return v;
    endfunction

    // One clock: compare outputs at the falling edge, advance the model, step past the rising edge.
    task automatic tick();
        bit rdy [2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic eo;
            eo = mact[i] ? (msbf[i] ? mword[i][3 - mpos[i]] : mword[i][mpos[i]]) : 1'b0;
            rdy[i] = !mact[i] || (mpos[i] == 3 && shift_en);
            chk($sformatf("serial_out%0d", i), so[i], eo);
            chk($sformatf("serial_valid%0d", i), sv[i], mact[i]);
            chk($sformatf("busy%0d", i), bz[i], mact[i]);
            chk($sformatf("last_bit%0d", i), lb[i], mact[i] && mpos[i] == 3);
            chk($sformatf("load_ready%0d", i), lr[i], rdy[i]);
            if (sv[i]) begin
                if (i == 0) cap0.push_back(so[0]);
                else        cap1.push_back(so[1]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mact[i] = 1'b0;
                mpos[i] = 0;
            end else begin
                if (mact[i] && shift_en) begin
                    mpos[i]++;
                    if (mpos[i] == 4) begin
                        mact[i] = 1'b0;
                        mpos[i] = 0;
                    end
                end
                if (load_valid && rdy[i]) begin
                    mword[i] = pin[i];
                    mpos[i]  = 0;
                    mact[i]  = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap0.delete();
        cap1.delete();
    endtask

    initial begin
        msbf[0] = 1'b1; msbf[1] = 1'b0;
        mact[0] = 1'b0; mact[1] = 1'b0;
        mpos[0] = 0;    mpos[1] = 0;
        pin[0] = 4'h0;  pin[1] = 4'h0;
        @(posedge clk); #1;

        // 1: reset then a single word
        rst = 1'b1; tick(); tick();
        rst = 1'b0; clear_caps();
        load_valid = 1'b1; pin[0] = 4'b1001; pin[1] = 4'b1001; tick();
        load_valid = 1'b0;
        repeat (5) tick();
        chk("t1_len", cap0.size(), 4);
        chk("t1_stream", pack(cap0), 4'b1001);

        // 2 + 6: back-to-back words with loopback reassembly
        clear_caps();
        load_valid = 1'b1; pin[0] = 4'b1001; pin[1] = 4'b1001; tick();
        load_valid = 1'b0; repeat (3) tick();
        load_valid = 1'b1; pin[0] = 4'b0110; pin[1] = 4'b0110; tick();
        load_valid = 1'b0;
        chk("t6_sipo_w0", sipo, 4'b1001);
        repeat (4) tick();
        chk("t6_sipo_w1", sipo, 4'b0110);
        tick();
        chk("t2_len", cap0.size(), 8);
        chk("t2_stream", pack(cap0), 8'b1001_0110);
        chk("t2_stream_lsb", pack(cap1), 8'b1001_0110);

        // 3: stall during bit 1
        clear_caps();
        load_valid = 1'b1; pin[0] = 4'b1100; pin[1] = 4'b1100; tick();
        load_valid = 1'b0; tick();
        shift_en = 1'b0; repeat (3) tick();
        shift_en = 1'b1; repeat (4) tick();
        chk("t3_len", cap0.size(), 7);
        chk("t3_stream", pack(cap0), 7'b1111100);
        chk("t3_stream_lsb", pack(cap1), 7'b0000011);

        // 4: reset during bit 2, with a load attempt on the reset edge
        clear_caps();
        load_valid = 1'b1; pin[0] = 4'b1011; pin[1] = 4'b1011; tick();
        load_valid = 1'b0; repeat (2) tick();
        rst = 1'b1; load_valid = 1'b1; tick();
        rst = 1'b0; load_valid = 1'b0;
        repeat (4) tick();
        chk("t4_len", cap0.size(), 3);
        chk("t4_stream", pack(cap0), 3'b101);

        // 5: load pulse while busy is ignored
        clear_caps();
        load_valid = 1'b1; pin[0] = 4'b0000; pin[1] = 4'b0001; tick();
        pin[0] = 4'b1111; pin[1] = 4'b1111;
        repeat (3) tick();
        load_valid = 1'b0; repeat (3) tick();
        chk("t5_stream", pack(cap0), 4'b0000);
        chk("t5_len", cap0.size(), 4);
        chk("t5_stream_lsb", pack(cap1), 4'b1000);

        // Random traffic, checked cycle by cycle against the model
        for (int n = 0; n < 500; n++) begin
            load_valid = ($urandom_range(1, 0) == 1);
            shift_en   = ($urandom_range(3, 0) != 0);
            pin[0]     = 4'($urandom);
            pin[1]     = 4'($urandom);
            rst        = ($urandom_range(49, 0) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
Parallel-in serial-out shifter; transmit-side counterpart of the team's SIPO receiver.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Streams the word out one bit per enabled clock, with a serial_valid qualifier and a last-bit marker.
- Supports back-to-back words with no idle gap.
- Feeds the SIPO directly: serial_out drives serial_in, and the word reassembles on parallel_out.

Parameters:
WIDTH, 4, word width in bits; legal range >= 2.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first (matches the SIPO shift-left fill); 0 = bit 0 is sent first.

Ports:
clk  input  1  rising-edge clock, the only clock
rst  input  1  synchronous, active-high reset
load_valid  input  1  parallel_in holds a word to send
load_ready  output  1  block can accept a word this cycle (combinational)
parallel_in  input  WIDTH  word to serialise; sampled only on an accept
shift_en  input  1  advance enable; 0 stalls the current bit
serial_out  output  1  current serial bit
serial_valid  output  1  serial_out carries a frame bit
last_bit  output  1  serial_out is the final bit of the current word
busy  output  1  a frame is in progress (equals serial_valid)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge.
- State: FSM with two states, IDLE and SHIFT. Internal shift register sreg[WIDTH-1:0]. Bit counter cnt, $clog2(WIDTH) bits wide, holding values 0..WIDTH-1.
- Reset values: state=IDLE, sreg=0, cnt=0. Outputs serial_out=0, serial_valid=0, busy=0, last_bit=0, load_ready=1.
- Accept rule: a word is accepted on an edge where load_valid=1 and load_ready=1.
- load_ready = (state==IDLE) OR (state==SHIFT AND cnt==WIDTH-1 AND shift_en).
- IDLE:
  - On accept: sreg<=parallel_in, cnt<=0, state<=SHIFT.
  - Otherwise hold.
  - serial_out=0 and serial_valid=0 throughout IDLE.
- SHIFT:
  - serial_out = sreg[WIDTH-1] when MSB_FIRST=1, else sreg[0].
  - serial_valid=1 and busy=1.
  - last_bit = (cnt==WIDTH-1).
- SHIFT, edge with shift_en=1 and cnt<WIDTH-1:
  - sreg shifts toward the output end (left if MSB_FIRST, right otherwise) with 0 filled in.
  - cnt<=cnt+1.
- SHIFT, edge with shift_en=1 and cnt==WIDTH-1 (end of frame):
  - If load_valid=1: accept the new word (sreg<=parallel_in, cnt<=0, stay in SHIFT). This gives zero bubble between words.
  - Else: state<=IDLE, cnt<=0.
- SHIFT, edge with shift_en=0: sreg, cnt and state all hold. serial_out, serial_valid and last_bit are unchanged.
- Latency: first bit appears in the cycle after the accept edge. A frame with no stalls occupies exactly WIDTH cycles of serial_valid=1.
- load_valid while load_ready=0: ignored. parallel_in is not sampled. The upstream block must hold the word until it sees ready.
- shift_en in IDLE: no effect.
- Reset mid-frame: the frame is aborted, partial bits are discarded, and all reset values apply on the next cycle. A load_valid on the reset edge is not accepted.
- Output timing: serial_out, serial_valid and busy are functions of registered state only, with no combinational path from inputs. load_ready depends combinationally on shift_en.

Test Plan:
1. Reset then single word: rst=1 for 2 cycles, then accept 4'b1001 with shift_en=1. Required: serial_out=1,0,0,1 on the 4 cycles after accept; serial_valid=1 for exactly those 4 cycles; last_bit=1 only on the 4th; then IDLE with serial_out=0 and load_ready=1.
2. Back-to-back: hold load_valid=1 with 4'b1001 then 4'b0110 presented at the last-bit cycle. Required: 8 contiguous serial_valid cycles carrying 1,0,0,1,0,1,1,0; load_ready=1 only in the first accept cycle and in each last-bit cycle.
3. Stall: send 4'b1100 with shift_en=0 for 3 cycles during bit 1. Required: serial_out holds 1 for 4 cycles; the stream is 1,1,0,0 with 7 serial_valid cycles in total; last_bit is held while stalled.
4. Reset mid-frame: assert rst during bit 2 of 4'b1011. Required: the next cycle shows serial_valid=0, serial_out=0, load_ready=1, and no further bits are emitted.
5. Busy-time load: pulse load_valid with 4'b1111 during bits 0–2 of a 4'b0000 frame. Required: the pulse is ignored and the output stays 0,0,0,0, then IDLE. Repeat with MSB_FIRST=0 and 4'b0001: required stream is 1,0,0,0.
6. Loopback: connect serial_out to the SIPO serial_in on the same clk/rst and send 4'b1001 then 4'b0110. Required: SIPO parallel_out equals 4'b1001 one cycle after that word's last_bit, and 4'b0110 four cycles later.
